blackjack_timer: RTL and testbench
==================================

Name: blackjack_timer

Overview:
Multi-mode timer/counter for the BlackJack datapath. It replaces a separate 2 kHz clock domain with an internal prescaler running on clk_50M. It provides three modes:
- a free-running seed counter, whose value is sampled for card randomisation;
- a one-shot timer with a runtime-programmable terminal count, used for delays such as the 2-second display hold;
- a periodic mode for blink/refresh events.

All logic is in the single clk_50M domain.

Parameters:
WIDTH, 12, width of the count register and terminal input.
DIV, 25000, prescaler divide ratio: clk_50M cycles per tick (2 kHz at 50 MHz). Legal range DIV >= 2.

Ports:
clk_50M  input  1  system clock, 50 MHz
i_RstCounter  input  1  asynchronous active-high reset
i_Clear  input  1  synchronous clear of count, prescaler and flags
i_Mode  input  2  00 hold, 01 seed, 10 one-shot timer, 11 periodic
i_Terminal  input  WIDTH  terminal count for modes 10/11
o_Count  output  WIDTH  current count value
o_Tick  output  1  prescaler strobe, high one cycle every DIV cycles
o_Done  output  1  sticky terminal-reached flag
o_DonePulse  output  1  one-cycle pulse on each terminal event
o_Busy  output  1  high in mode 10 while o_Done is low

Behaviour:
Reset and clock
- Reset is i_RstCounter, asynchronous, active-high. Clock is clk_50M.
- On reset: o_Count=0, prescaler=0, o_Done=0, o_DonePulse=0, registered previous mode=00.
- Priority: reset > i_Clear > mode action.

Prescaler
- Free-running counter of width $clog2(DIV), counting 0..DIV-1 and wrapping to 0.
- o_Tick = (prescaler == DIV-1), combinational from the register.
- Runs in every mode.

i_Clear (sampled on an edge)
- Sets count=0, prescaler=0, o_Done=0, o_DonePulse=0.
- The next tick therefore falls DIV edges after the clear edge.

Mode-change rule
- The previous mode is registered every cycle.
- When i_Mode differs from the registered value: o_Done is cleared that edge and no increment occurs that edge.
- The count is retained across mode changes; only i_Clear zeroes it.

Mode 00, hold
- Count frozen. o_Done holds. o_DonePulse=0.

Mode 01, seed
- count <= count+1 on every clk_50M edge, ignoring ticks.
- Wraps from 2^WIDTH-1 to 0.
- o_Done and o_DonePulse are not set.

Mode 10, one-shot timer (acts only on tick edges)
- If o_Done=0 and count+1 == i_Terminal: count <= i_Terminal, o_Done <= 1, o_DonePulse <= 1.
- If o_Done=0 and count >= i_Terminal (terminal lowered, or leftover seed value): count holds, o_Done <= 1, o_DonePulse <= 1.
- If o_Done=1: count holds. No further pulses until i_Clear or a mode change.
- If i_Terminal=0: done on the first tick, count stays 0.
- Counting never wraps; the maximum value is i_Terminal.

Mode 11, periodic (acts only on tick edges)
- If count >= i_Terminal: count <= 0, o_DonePulse <= 1, o_Done <= 1 (sticky).
- Otherwise count <= count+1.
- Period is (i_Terminal+1) ticks. i_Terminal=0 gives a pulse on every tick.

Pulse and busy timing
- o_DonePulse is registered and high for exactly one cycle after the terminal edge; it is 0 on all other edges.
- o_Busy = (i_Mode == 10) & ~o_Done, combinational.

Other rules
- i_Terminal is sampled live at every tick edge.
- Changing i_Terminal mid-count takes effect at the next tick.
- Reset asserted mid-count returns all state to reset values immediately, without waiting for a clock edge.

Test Plan:
Bench setting for all scenarios: WIDTH=12, DIV=4.
1. Reset → o_Count=0, o_Done=0, o_DonePulse=0, o_Tick=0. Release reset; o_Tick first high in the cycle after the 3rd edge, then every 4 cycles.
2. i_Clear, mode 10, i_Terminal=5 → o_Count increments at edges 4,8,12,16,20 after the clear edge. After edge 20: o_Count=5, o_Done=1, o_DonePulse high one cycle, o_Busy=0. o_Count stays 5 for 100 further cycles with no further pulses.
3. Mode 01 from count=4093 for 5 edges → o_Count sequence 4094, 4095, 0, 1, 2. o_Done stays 0.
4. i_Clear, mode 11, i_Terminal=2 → o_Count sequence 1, 2, 0, 1, 2, 0 at 4-edge spacing. o_DonePulse at each wrap to 0 (edges 12 and 24 after the clear). o_Done=1 after the first wrap.
5. Mode 10, i_Terminal=9, count reaches 6; then i_Terminal changed to 3 → next tick: count holds at 6, o_Done=1, one o_DonePulse. Separately, i_Terminal=0 → done at the first tick with o_Count=0.
6. Assert i_RstCounter asynchronously mid-count at o_Count=7 in mode 10 → o_Count=0 and o_Done=0 immediately, before the next edge. Mode change 10→00 after done → o_Done cleared at that edge, o_Count retained.

Source files
------------

// File: rtl/blackjack_timer.sv
// Multi-mode timer/counter for the BlackJack datapath.
// A prescaler on clk_50M produces a one-cycle tick every DIV cycles. The count
// register is shared by three modes: a free-running seed counter, a one-shot
// timer with a live terminal count, and a periodic event generator.
module blackjack_timer #(
  parameter int WIDTH = 12,
  parameter int DIV   = 25000
) (
  input  logic             clk_50M,
  input  logic             i_RstCounter,
  input  logic             i_Clear,
  input  logic [1:0]       i_Mode,
  input  logic [WIDTH-1:0] i_Terminal,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Tick,
  output logic             o_Done,
  output logic             o_DonePulse,
  output logic             o_Busy
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_SEED     = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PERIODIC = 2'b11
  } mode_e;

  logic [PW-1:0] presc;
  mode_e         mode_q;
  mode_e         mode_in;
  logic          mode_change;
  logic [WIDTH:0] count_inc;   // one bit wider so the terminal match cannot alias on wrap

  assign mode_in     = mode_e'(i_Mode);
  assign mode_change = (mode_in != mode_q);
  assign count_inc   = {1'b0, o_Count} + (WIDTH+1)'(1);

  // Tick and busy are decoded straight from registered state and the live mode.
  assign o_Tick = (presc == PRESC_LAST);
  assign o_Busy = (mode_in == MODE_ONESHOT) & ~o_Done;

  // Prescaler, mode history, count and flags; clear outranks every mode action.
  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see this edge's new values.
  always_ff @(posedge clk_50M or posedge i_RstCounter) begin
    if (i_RstCounter) begin
      presc       <= '0;
      mode_q      <= MODE_HOLD;
      o_Count     <= '0;
      o_Done      <= 1'b0;
      o_DonePulse <= 1'b0;
    end else begin
      mode_q <= mode_in;
      if (i_Clear) begin
        presc       <= '0;
        o_Count     <= '0;
        o_Done      <= 1'b0;
        o_DonePulse <= 1'b0;
      end else begin
        presc       <= o_Tick ? '0 : presc + PW'(1);
        o_DonePulse <= 1'b0;
        if (mode_change) begin
          // A new mode starts without a stale done flag and without counting.
          o_Done <= 1'b0;
        end else begin
          case (mode_in)
            MODE_SEED: begin
              o_Count <= o_Count + WIDTH'(1);
            end
            MODE_ONESHOT: begin
              if (o_Tick && !o_Done) begin
                if (o_Count >= i_Terminal) begin
                  // Terminal already passed (lowered, or leftover seed value).
                  o_Done      <= 1'b1;
                  o_DonePulse <= 1'b1;
                end else if (count_inc == {1'b0, i_Terminal}) begin
                  o_Count     <= i_Terminal;
                  o_Done      <= 1'b1;
                  o_DonePulse <= 1'b1;
                end else begin
                  o_Count <= count_inc[WIDTH-1:0];
                end
              end
            end
            MODE_PERIODIC: begin
              if (o_Tick) begin
                if (o_Count >= i_Terminal) begin
                  o_Count     <= '0;
                  o_Done      <= 1'b1;
                  o_DonePulse <= 1'b1;
                end else begin
                  o_Count <= count_inc[WIDTH-1:0];
                end
              end
            end
            default: ;  // hold: count and done frozen
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_blackjack_timer.sv
// Self-checking bench for blackjack_timer (WIDTH=12, DIV=4).
// The driver advances a behavioural model each edge and queues the expected
// outputs; an independent monitor pops and compares on every falling edge.
module tb_blackjack_timer;

  localparam int WIDTH = 12;
  localparam int DIV   = 4;
  localparam int MODV  = 1 << WIDTH;

  logic             clk_50M = 1'b0;
  logic             i_RstCounter;
  logic             i_Clear;
  logic [1:0]       i_Mode;
  logic [WIDTH-1:0] i_Terminal;
  logic [WIDTH-1:0] o_Count;
  logic             o_Tick;
  logic             o_Done;
  logic             o_DonePulse;
  logic             o_Busy;

  blackjack_timer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk_50M     (clk_50M),
    .i_RstCounter(i_RstCounter),
    .i_Clear     (i_Clear),
    .i_Mode      (i_Mode),
    .i_Terminal  (i_Terminal),
    .o_Count     (o_Count),
    .o_Tick      (o_Tick),
    .o_Done      (o_Done),
    .o_DonePulse (o_DonePulse),
    .o_Busy      (o_Busy)
  );

  always #5 clk_50M = ~clk_50M;

  typedef struct {
    int   count;
    logic tick;
    logic done;
    logic pulse;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: edges since reset/clear, count as an integer, flags.
  int   m_edges;
  int   m_count;
  logic m_done;
  logic m_pulse;
  int   m_prev_mode;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_edges     = 0;
    m_count     = 0;
    m_done      = 1'b0;
    m_pulse     = 1'b0;
    m_prev_mode = 0;
  endtask

  // One clock edge of the specified behaviour, given the inputs seen at it.
  task automatic model_edge(input logic clr, input int mode, input int term);
    bit tick_now = ((m_edges % DIV) == DIV - 1);
    if (clr) begin
      m_edges = 0;
      m_count = 0;
      m_done  = 1'b0;
      m_pulse = 1'b0;
    end else begin
      m_edges++;
      m_pulse = 1'b0;
      if (mode != m_prev_mode) begin
        m_done = 1'b0;
      end else if (mode == 1) begin
        m_count = (m_count + 1) % MODV;
      end else if (mode == 2 && tick_now && !m_done) begin
        if (m_count < term) m_count = m_count + 1;
        if (m_count >= term) begin
          m_done  = 1'b1;
          m_pulse = 1'b1;
        end
      end else if (mode == 3 && tick_now) begin
        if (m_count >= term) begin
          m_count = 0;
          m_done  = 1'b1;
          m_pulse = 1'b1;
        end else begin
          m_count = m_count + 1;
        end
      end
    end
    m_prev_mode = mode;
  endtask

  // Drive one cycle of inputs, model the edge, queue the expected outputs.
  task automatic step(input logic clr, input logic [1:0] mode, input int term);
    exp_t e;
    i_Clear    = clr;
    i_Mode     = mode;
    i_Terminal = WIDTH'(term);
    @(posedge clk_50M);
    model_edge(clr, int'(mode), term);
    e.count = m_count;
    e.tick  = ((m_edges % DIV) == DIV - 1);
    e.done  = m_done;
    e.pulse = m_pulse;
    e.busy  = (mode == 2'b10) && !m_done;
    exp_q.push_back(e);
    @(negedge clk_50M);
    #1;
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50M);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(o_Count), e.count);
        check("tick",  int'(o_Tick), int'(e.tick));
        check("done",  int'(o_Done), int'(e.done));
        check("pulse", int'(o_DonePulse), int'(e.pulse));
        check("busy",  int'(o_Busy), int'(e.busy));
      end
    end
  end

  initial begin
    int guard;
    int mode_r;
    int term_r;

    // Scenario 1: reset state and tick cadence.
    i_RstCounter = 1'b1;
    i_Clear      = 1'b0;
    i_Mode       = 2'b00;
    i_Terminal   = '0;
    model_reset();
    #3;
    check("rst_count", int'(o_Count), 0);
    check("rst_done",  int'(o_Done), 0);
    check("rst_pulse", int'(o_DonePulse), 0);
    check("rst_tick",  int'(o_Tick), 0);
    @(negedge clk_50M);
    @(negedge clk_50M);
    #1;
    i_RstCounter = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 0);

    // Scenario 2: one-shot to 5, then long hold with no further pulses.
    step(1'b1, 2'b10, 5);
    for (int i = 0; i < 20; i++) step(1'b0, 2'b10, 5);
    check("oneshot_count", int'(o_Count), 5);
    check("oneshot_done",  int'(o_Done), 1);
    check("oneshot_busy",  int'(o_Busy), 0);
    for (int i = 0; i < 100; i++) step(1'b0, 2'b10, 5);
    check("oneshot_hold", int'(o_Count), 5);

    // Scenario 3: seed counter wrap from 4093.
    step(1'b1, 2'b01, 0);
    for (int i = 0; i < 4093; i++) step(1'b0, 2'b01, 0);
    check("seed_at_4093", int'(o_Count), 4093);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 0);
    check("seed_wrap", int'(o_Count), 2);
    check("seed_done", int'(o_Done), 0);

    // Scenario 4: periodic with terminal 2.
    step(1'b1, 2'b11, 2);
    for (int i = 0; i < 24; i++) step(1'b0, 2'b11, 2);
    check("periodic_count", int'(o_Count), 0);
    check("periodic_done",  int'(o_Done), 1);

    // Scenario 5: terminal lowered below the count, then terminal 0.
    step(1'b1, 2'b10, 9);
    guard = 0;
    while (m_count != 6 && guard < 100) begin
      step(1'b0, 2'b10, 9);
      guard++;
    end
    check("reach_6_in_budget", int'(guard < 100), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b10, 3);
    check("lowered_count", int'(o_Count), 6);
    check("lowered_done",  int'(o_Done), 1);
    step(1'b1, 2'b10, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b10, 0);
    check("term0_count", int'(o_Count), 0);
    check("term0_done",  int'(o_Done), 1);

    // Scenario 6: asynchronous reset mid-count, then 10->00 after done.
    step(1'b1, 2'b10, 20);
    guard = 0;
    while (m_count != 7 && guard < 100) begin
      step(1'b0, 2'b10, 20);
      guard++;
    end
    check("reach_7_in_budget", int'(guard < 100), 1);
    i_RstCounter = 1'b1;
    #1;
    check("async_rst_count", int'(o_Count), 0);
    check("async_rst_done",  int'(o_Done), 0);
    model_reset();
    #1;
    i_RstCounter = 1'b0;
    step(1'b1, 2'b10, 3);
    for (int i = 0; i < 16; i++) step(1'b0, 2'b10, 3);
    check("pre_change_done", int'(o_Done), 1);
    step(1'b0, 2'b00, 3);
    check("mode_change_done",  int'(o_Done), 0);
    check("mode_change_count", int'(o_Count), 3);

    // Randomised traffic: sticky modes, small terminals, occasional clears.
    mode_r = 0;
    term_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) term_r = int'($urandom_range(0, 12));
      step(($urandom_range(0, 199) == 0), 2'(mode_r), term_r);
    end

    @(negedge clk_50M);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
